// File: rtl/qa_out_fifo.sv
// rtl/qa_out_fifo.sv - show-ahead output buffer behind qa_wrapper with a sticky overflow flag
module qa_out_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      in_data,
  input  logic                  in_nd,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wp;
  logic [DEPTH_LOG2-1:0] rp;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  overflow_q;
  logic                  push;
  logic                  pop;
  logic                  drop;

  // Status flags come only from registered occupancy, never from the strobes.
  assign out_valid = (count_q != '0);
  assign full      = (count_q == COUNT_FULL);
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A full buffer still accepts a sample when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = in_nd & (~full | pop);
  assign drop = in_nd & full & ~pop;

  assign out_data = mem[rp];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) begin
        wp <= wp + 1'b1;
      end
      if (pop) begin
        rp <= rp + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow_q <= 1'b0;
    end else if (drop) begin
      overflow_q <= 1'b1;
    end
  end

endmodule
